rs232_tx_arbiter: RTL and testbench

//  Shares the RS232 UART transmit path among NUM_REQ byte-stream requesters. Drives the UART's

---
 rtl/rs232_tx_arbiter_if.sv | 30 +++
 rtl/rs232_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_rs232_tx_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_tx_arbiter_if.sv
// Avalon-MM slave port of the RS232 UART, as seen by its single master (the TX arbiter).
interface rs232_tx_arbiter_if;
  logic        uart_address;
  logic        uart_chipselect;
  logic [3:0]  uart_byteenable;
  logic        uart_read;
  logic        uart_write;
  logic [31:0] uart_writedata;
  logic [31:0] uart_readdata;

  modport master (
    output uart_address,
    output uart_chipselect,
    output uart_byteenable,
    output uart_read,
    output uart_write,
    output uart_writedata,
    input  uart_readdata
  );

  modport slave (
    input  uart_address,
    input  uart_chipselect,
    input  uart_byteenable,
    input  uart_read,
    input  uart_write,
    input  uart_writedata,
    output uart_readdata
  );
endinterface

// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing the RS232 UART TX path, with credit from polled write_space.
// Define RS232_ARB_PKT_LOCK_EN to hold the grant for a whole packet (until req_last).
module rs232_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_BURST     = 64,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [2:0]             grant_id,
  output logic                   busy,
  rs232_tx_arbiter_if.master     uart
);

`ifdef RS232_ARB_PKT_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  localparam logic [7:0]         MaxBurst = 8'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] OneHot0  = NUM_REQ'(1);

  typedef enum logic [2:0] {
    StIdle, StPoll, StPollWait, StBackoff, StSend, StSettle
  } state_e;

  state_e       state_q, state_d;
  logic [2:0]   owner_q, owner_d;
  logic [2:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]   credit_q, credit_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         lock_q, lock_d;
  logic [7:0]   wdata_q, wdata_d;

  logic [NUM_REQ-1:0] owner_oh;
  logic               owner_valid, owner_last, locked, wr, release_owner;
  logic [7:0]         owner_byte, space;
  logic [2:0]         pick;

  // First valid requester after ptr, wrapping; ptr itself is checked last.
  function automatic logic [2:0] rr_pick(input logic [2:0] ptr, input logic [NUM_REQ-1:0] valid);
    logic [2:0]  sel;
    logic        found;
    int unsigned idx;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!found && |(valid & (OneHot0 << idx))) begin
        sel   = 3'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign owner_oh    = OneHot0 << owner_q;
  assign owner_valid = |(req_valid & owner_oh);
  assign owner_last  = |(req_last & owner_oh);
  assign owner_byte  = 8'(req_data >> {owner_q, 3'b000});
  assign locked      = LockEn && lock_q;
  assign pick        = rr_pick(rr_ptr_q, req_valid);
  assign space       = uart.uart_readdata[23:16];

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rr_ptr_d      = rr_ptr_q;
    credit_d      = credit_q;
    cnt_d         = cnt_q;
    lock_d        = lock_q;
    wdata_d       = wdata_q;
    req_ready     = '0;
    wr            = 1'b0;
    release_owner = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          if (!locked) owner_d = pick;
          state_d = (credit_q == 8'd0) ? StPoll : StSend;
        end
      end
      StPoll: state_d = StPollWait;
      StPollWait: begin
        credit_d = (space > MaxBurst) ? MaxBurst : space;
        cnt_d    = '0;
        state_d  = (space == 8'd0) ? StBackoff : StSend;
      end
      StBackoff: begin
        if (cnt_q == 16'(POLL_INTERVAL - 1)) state_d = StPoll;
        else                                 cnt_d   = cnt_q + 16'd1;
      end
      StSettle: begin
        if (cnt_q == 16'(SETTLE_CYCLES - 1)) state_d = StPoll;
        else                                 cnt_d   = cnt_q + 16'd1;
      end
      StSend: begin
        if (owner_valid) begin
          req_ready     = owner_oh;
          wr            = 1'b1;
          wdata_d       = owner_byte;
          credit_d      = credit_q - 8'd1;
          release_owner = !LockEn || owner_last;
          lock_d        = LockEn && !owner_last;
          if (release_owner) begin
            rr_ptr_d = owner_q;
            owner_d  = rr_pick(owner_q, req_valid);
          end
          if (credit_q == 8'd1) begin
            state_d = StSettle;
            cnt_d   = '0;
          end
        end else if (!locked) begin
          // An idle, unlocked owner must not starve the others.
          if (|req_valid) owner_d = pick;
          else            state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      owner_q  <= '0;
      rr_ptr_q <= 3'(NUM_REQ - 1);
      credit_q <= '0;
      cnt_q    <= '0;
      lock_q   <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      cnt_q    <= cnt_d;
      lock_q   <= lock_d;
      wdata_q  <= wdata_d;
    end
  end

  // Write strobes follow the handshake in the same cycle; reads come straight from state.
  assign uart.uart_read       = (state_q == StPoll);
  assign uart.uart_write      = wr;
  assign uart.uart_chipselect = uart.uart_read | wr;
  assign uart.uart_address    = uart.uart_read;
  assign uart.uart_byteenable = uart.uart_read ? 4'hF : (wr ? 4'h1 : 4'h0);
  assign uart.uart_writedata  = wr ? {24'h0, owner_byte} : {24'h0, wdata_q};

  assign grant_id = owner_q;
  assign busy     = (state_q != StIdle);

  logic unused_readdata;
  assign unused_readdata = ^{uart.uart_readdata[31:24], uart.uart_readdata[15:0]};

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Scoreboard bench for rs232_tx_arbiter: table-driven traffic scenarios plus reset, backoff
// and credit-boundary sequences.
module tb_rs232_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [2:0]  grant_id;
  logic        busy;
  logic [7:0]  space = '0;

  rs232_tx_arbiter_if u_if ();
  assign u_if.uart_readdata = {8'h00, space, 16'h0000};

  rs232_tx_arbiter #(
    .NUM_REQ(4), .MAX_BURST(64), .SETTLE_CYCLES(3), .POLL_INTERVAL(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant_id(grant_id), .busy(busy), .uart(u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sp; int n0; int n2; int exp_polls; int exp_writes;
  } vec_t;

  int errors = 0, checks = 0;
  logic [8:0] mem [4][128];
  int cnt [4];
  int idx [4];
  logic [7:0] exp_q [$];
  int poll_wr [$];
  int wr_cnt, hs_cnt, poll_cnt, cyc, prev_poll, last_poll, first_wr, last_wr;
  bit chk_data;
  logic [7:0] last_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (idx[i] < cnt[i]) begin
        req_valid[i]      = 1'b1;
        req_data[8*i +: 8] = mem[i][idx[i]][7:0];
        req_last[i]       = mem[i][idx[i]][8];
      end else begin
        req_valid[i]      = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]       = 1'b0;
      end
    end
  endtask

  task automatic tick();
    logic [3:0] hs;
    @(negedge clk);
    check("rd_wr_exclusive", {31'h0, u_if.uart_read & u_if.uart_write}, 32'h0);
    check("ready_owner_only", {28'h0, req_ready & ~(4'b0001 << grant_id)}, 32'h0);
    if (u_if.uart_read) begin
      check("poll_addr", {31'h0, u_if.uart_address}, 32'h1);
      poll_cnt++;
      prev_poll = last_poll;
      last_poll = cyc;
      poll_wr.push_back(wr_cnt);
    end
    if (u_if.uart_write) begin
      check("write_be", {28'h0, u_if.uart_byteenable}, 32'h1);
      check("write_addr", {31'h0, u_if.uart_address}, 32'h0);
      if (wr_cnt == 0) first_wr = cyc;
      last_wr = cyc;
      wr_cnt++;
      if (chk_data) begin
        if (exp_q.size() == 0) check("wdata_unexpected", u_if.uart_writedata, 32'hFFFF_FFFF);
        else check("wdata", u_if.uart_writedata, {24'h0, exp_q.pop_front()});
      end
    end
    hs = req_valid & req_ready;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        hs_cnt++;
        idx[i]++;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_traffic();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      idx[i] = 0;
    end
    exp_q.delete();
    poll_wr.delete();
    wr_cnt = 0; hs_cnt = 0; poll_cnt = 0; prev_poll = 0; last_poll = 0;
    first_wr = 0; last_wr = 0;
    chk_data = 1'b1;
    drive();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_traffic();
    repeat (2) @(posedge clk);
    #1;
    check("rst_write", {31'h0, u_if.uart_write}, 32'h0);
    check("rst_read", {31'h0, u_if.uart_read}, 32'h0);
    check("rst_cs", {31'h0, u_if.uart_chipselect}, 32'h0);
    check("rst_be", {28'h0, u_if.uart_byteenable}, 32'h0);
    check("rst_wdata", u_if.uart_writedata, 32'h0);
    check("rst_busy_grant", {28'h0, busy, grant_id}, 32'h0);
    reset_n = 1'b1;
  endtask

  task automatic load(input int i, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) mem[i][cnt[i] + k] = {k == n - 1, base + 8'(k)};
    cnt[i] += n;
  endtask

  task automatic push_exp(input logic [7:0] b);
    exp_q.push_back(b);
    last_exp = b;
  endtask

  // Expected write order for req0/req2 streams (each one packet, last on its final byte).
  task automatic push_order(input int n0, input logic [7:0] b0, input int n2, input logic [7:0] b2);
    int i0, i2;
    bit turn2;
    i0 = 0; i2 = 0; turn2 = 1'b0;
`ifdef RS232_ARB_PKT_LOCK_EN
    for (int k = 0; k < n0; k++) push_exp(b0 + 8'(k));
    for (int k = 0; k < n2; k++) push_exp(b2 + 8'(k));
`else
    while (i0 < n0 || i2 < n2) begin
      if ((!turn2 && i0 < n0) || i2 >= n2) begin
        push_exp(b0 + 8'(i0)); i0++; turn2 = 1'b1;
      end else begin
        push_exp(b2 + 8'(i2)); i2++; turn2 = 1'b0;
      end
    end
`endif
  endtask

  task automatic run_until_idle(input int max);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    while (!done && t < max) begin
      tick();
      t++;
      done = !busy;
      for (int i = 0; i < 4; i++) if (idx[i] < cnt[i]) done = 1'b0;
    end
    check("idle_timeout", {31'h0, done}, 32'h1);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{sp: 128, n0: 3,  n2: 0, exp_polls: 1, exp_writes: 3};
    vecs[1] = '{sp: 2,   n0: 5,  n2: 0, exp_polls: 3, exp_writes: 5};
    vecs[2] = '{sp: 200, n0: 4,  n2: 4, exp_polls: 1, exp_writes: 8};
    vecs[3] = '{sp: 1,   n0: 2,  n2: 2, exp_polls: 5, exp_writes: 4};
    vecs[4] = '{sp: 3,   n0: 3,  n2: 3, exp_polls: 3, exp_writes: 6};
    vecs[5] = '{sp: 64,  n0: 0,  n2: 5, exp_polls: 1, exp_writes: 5};
    vecs[6] = '{sp: 64,  n0: 64, n2: 0, exp_polls: 2, exp_writes: 64};
    cyc = 0;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      space = 8'(vecs[v].sp);
      load(0, vecs[v].n0, 8'h41);
      load(2, vecs[v].n2, 8'h81);
      push_order(vecs[v].n0, 8'h41, vecs[v].n2, 8'h81);
      drive();
      run_until_idle(600);
      check("vec_writes", wr_cnt, vecs[v].exp_writes);
      check("vec_polls", poll_cnt, vecs[v].exp_polls);
      check("vec_exp_drained", exp_q.size(), 0);
      check("vec_hs_eq_wr", hs_cnt, wr_cnt);
      check("vec_wdata_hold", u_if.uart_writedata, {24'h0, last_exp});
    end

    // Reset in the middle of a write burst, then RR restarts at requester 0.
    do_reset();
    space = 8'd128;
    chk_data = 1'b0;
    for (int i = 0; i < 4; i++) load(i, 8, 8'(16 * (i + 1)));
    drive();
    for (int t = 0; t < 20 && wr_cnt < 2; t++) tick();
    @(negedge clk);
    check("midsend_write", {31'h0, u_if.uart_write}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("midsend_rst_write", {31'h0, u_if.uart_write}, 32'h0);
    check("midsend_rst_cs", {31'h0, u_if.uart_chipselect}, 32'h0);
    check("midsend_rst_ready", {28'h0, req_ready}, 32'h0);
    check("midsend_rst_wdata", u_if.uart_writedata, 32'h0);
    clear_traffic();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load(i, 1, 8'hA0 + 8'(i));
      push_exp(8'hA0 + 8'(i));
    end
    drive();
    run_until_idle(200);
    check("postrst_writes", wr_cnt, 4);
    check("postrst_drained", exp_q.size(), 0);

    // No space: repoll POLL_INTERVAL+2 cycles after the previous poll.
    do_reset();
    space = 8'd0;
    load(0, 1, 8'h55);
    push_exp(8'h55);
    drive();
    for (int t = 0; t < 80 && poll_cnt < 2; t++) tick();
    check("backoff_polls", poll_cnt, 2);
    check("repoll_gap", last_poll - prev_poll, 18);
    check("backoff_no_write", wr_cnt, 0);
    space = 8'd5;
    run_until_idle(100);
    check("backoff_then_write", wr_cnt, 1);

    // 3 bytes from a 64-credit poll leave 61: exactly 61 more go out before the next poll.
    do_reset();
    space = 8'd128;
    load(0, 3, 8'h41);
    push_order(3, 8'h41, 0, 8'h00);
    drive();
    run_until_idle(100);
    check("burst3_writes", wr_cnt, 3);
    check("burst3_consecutive", last_wr - first_wr, 2);
    space = 8'd0;
    load(0, 62, 8'h60);
    for (int k = 0; k < 61; k++) push_exp(8'h60 + 8'(k));
    drive();
    repeat (120) tick();
    check("credit_writes", wr_cnt, 64);
    check("credit_poll_after", poll_wr.size() > 1 ? poll_wr[1] : -1, 64);
    check("credit_drained", exp_q.size(), 0);
    check("credit_pending", {31'h0, req_valid[0]}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
